// File: rtl/wino_input_transform_stream.sv
// wino_input_transform_stream
//
// Streaming Winograd F(2x2,3x3) input-tile transform. Each accepted beat carries one
// signed 4x4 tile d, and the block produces V = B^T * d * B two cycles later. A per-beat
// bypass mode instead passes d through, sign-extended to WO bits.
//
// Pipeline:
//   S1 holds T = B^T * d, the column transform. In bypass it holds d itself.
//   S2 holds V = T * B, the row transform. In bypass it holds T unchanged.
//   S2 drives the outputs directly.
//   Both stages advance together whenever S2 is empty or is being drained.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat
//   in_data    tile d; element k = 4r+c at in_data[k*WI +: WI]
//   in_mode    0 = transform, 1 = bypass
//   in_tag     sideband tag travelling with the beat
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_data   tile V; element k at out_data[k*WO +: WO]
//   out_tag    tag of the beat on out_data
//   out_count  completed output transfers, modulo 2^CW

module wino_input_transform_stream #(
  parameter int unsigned WI = 8,
  parameter int unsigned WO = 12,
  parameter int unsigned TW = 4,
  parameter int unsigned CW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [16*WI-1:0]  in_data,
  input  logic              in_mode,
  input  logic [TW-1:0]     in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [16*WO-1:0]  out_data,
  output logic [TW-1:0]     out_tag,
  output logic [CW-1:0]     out_count
);

  // Two add/subtract levels grow the magnitude by at most 2 bits, so anything narrower
  // than WI+2 could wrap.
  if (WO < WI + 2) begin : g_width_check
    $error("wino_input_transform_stream: WO must be >= WI+2");
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic adv;

  // The whole pipe moves as one unit. It advances when the output slot is free
  // or is being consumed in this cycle.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv & !rst;

  // ---------------------------------------------------------------------------
  // Stage 1: column transform T = B^T * d
  // ---------------------------------------------------------------------------
  logic signed [WO-1:0] d_ext    [16];
  logic signed [WO-1:0] s1_t_d   [16];
  logic signed [WO-1:0] s1_t_q   [16];
  logic                 s1_valid_q;
  logic                 s1_mode_q;
  logic [TW-1:0]        s1_tag_q;

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      d_ext[k] = WO'($signed(in_data[k*WI +: WI]));
    end
    for (int k = 0; k < 16; k++) begin
      s1_t_d[k] = '0;
    end
    if (in_mode) begin
      for (int k = 0; k < 16; k++) begin
        s1_t_d[k] = d_ext[k];
      end
    end else begin
      // Row index r is k/4, so column c reads rows 0..3 as d_ext[c], [4+c], [8+c], [12+c].
      for (int c = 0; c < 4; c++) begin
        s1_t_d[c]      = d_ext[c]     - d_ext[8+c];
        s1_t_d[4+c]    = d_ext[4+c]   + d_ext[8+c];
        s1_t_d[8+c]    = d_ext[8+c]   - d_ext[4+c];
        s1_t_d[12+c]   = d_ext[4+c]   - d_ext[12+c];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: row transform V = T * B
  // ---------------------------------------------------------------------------
  logic signed [WO-1:0] v_d [16];
  logic [16*WO-1:0]     out_data_d;

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      v_d[k] = '0;
    end
    if (s1_mode_q) begin
      for (int k = 0; k < 16; k++) begin
        v_d[k] = s1_t_q[k];
      end
    end else begin
      for (int r = 0; r < 4; r++) begin
        v_d[4*r]     = s1_t_q[4*r]   - s1_t_q[4*r+2];
        v_d[4*r+1]   = s1_t_q[4*r+1] + s1_t_q[4*r+2];
        v_d[4*r+2]   = s1_t_q[4*r+2] - s1_t_q[4*r+1];
        v_d[4*r+3]   = s1_t_q[4*r+1] - s1_t_q[4*r+3];
      end
    end
    out_data_d = '0;
    for (int k = 0; k < 16; k++) begin
      out_data_d[k*WO +: WO] = v_d[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers and transfer counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_tag_q   <= '0;
      for (int k = 0; k < 16; k++) begin
        s1_t_q[k] <= '0;
      end
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      out_count  <= '0;
    end else begin
      if (adv) begin
        // in_ready equals adv outside reset, so in_valid here marks an accepted beat.
        s1_valid_q <= in_valid;
        s1_mode_q  <= in_mode;
        s1_tag_q   <= in_tag;
        s1_t_q     <= s1_t_d;
        out_valid  <= s1_valid_q;
        out_data   <= out_data_d;
        out_tag    <= s1_tag_q;
      end
      if (out_valid && out_ready) begin
        out_count <= out_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wino_input_transform_stream.sv
// Directed self-checking bench for wino_input_transform_stream.
module tb_wino_input_transform_stream;

  localparam int WI = 8;
  localparam int WO = 12;
  localparam int TW = 4;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [16*WI-1:0]  in_data;
  logic              in_mode;
  logic [TW-1:0]     in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [16*WO-1:0]  out_data;
  logic [TW-1:0]     out_tag;
  logic [CW-1:0]     out_count;

  always #5 clk = ~clk;

  wino_input_transform_stream #(
    .WI (WI),
    .WO (WO),
    .TW (TW),
    .CW (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_count (out_count)
  );

  int checks = 0;
  int errors = 0;
  int tv [16];
  int ev [16];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint elem(input int k);
    logic [WO-1:0] x;
    x = out_data[k*WO +: WO];
    return longint'($signed(x));
  endfunction

  task automatic load_tile(input logic mode, input logic [TW-1:0] tag);
    for (int k = 0; k < 16; k++) begin
      in_data[k*WI +: WI] = WI'(tv[k]);
    end
    in_mode = mode;
    in_tag  = tag;
  endtask

  task automatic fill_tv(input int v);
    for (int k = 0; k < 16; k++) tv[k] = v;
  endtask

  task automatic fill_ev(input int v);
    for (int k = 0; k < 16; k++) ev[k] = v;
  endtask

  // Called just after a rising edge. It sends tv as one beat and checks the two-cycle
  // latency, the tag and every element against ev. It returns with the beat on the
  // outputs.
  task automatic beat(input string name, input logic mode, input logic [TW-1:0] tag);
    load_tile(mode, tag);
    in_valid = 1'b1;
    #1;
    check({name, "_in_ready"}, longint'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_lat1_valid"}, longint'(out_valid), 0);
    @(posedge clk); #1;
    check({name, "_lat2_valid"}, longint'(out_valid), 1);
    check({name, "_tag"}, longint'(out_tag), longint'(tag));
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s_v%0d", name, k), elem(k), longint'(ev[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int got;
    int stalls;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset and idle behaviour.
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_in_ready", longint'(in_ready), 0);
    end
    check("rst_out_data_nz", longint'(out_data != '0), 0);
    check("rst_out_tag", longint'(out_tag), 0);
    check("rst_out_count", longint'(out_count), 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", longint'(in_ready), 1);
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_out_valid", longint'(out_valid), 0);
    end

    // All-ones tile: only V11 is nonzero.
    fill_tv(1);
    fill_ev(0);
    ev[5] = 4;
    beat("ones", 1'b0, 4'd1);
    @(posedge clk); #1;

    // Ramp tile d[k] = k.
    for (int k = 0; k < 16; k++) tv[k] = k;
    ev = '{0, -16, 0, 0, -4, 30, 2, -4, 0, 8, 0, 0, 0, -16, 0, 0};
    beat("ramp", 1'b0, 4'd2);
    @(posedge clk); #1;

    // Most negative input, transform mode.
    fill_tv(-128);
    fill_ev(0);
    ev[5] = -512;
    beat("neg", 1'b0, 4'd3);
    check("neg_raw_v5", longint'(out_data[5*WO +: WO]), 'hE00);
    @(posedge clk); #1;

    // Same tile in bypass mode.
    fill_ev(-128);
    beat("byp", 1'b1, 4'd4);
    check("byp_raw_v0", longint'(out_data[0 +: WO]), 'hF80);
    @(posedge clk); #1;
    check("count_after4", longint'(out_count), 4);

    // Reset clears the counter.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2_count", longint'(out_count), 0);

    // Back-pressure: five bypass beats, where beat n carries tag n and elements n.
    // out_ready is low for loop cycles 3..6.
    sent   = 0;
    got    = 0;
    stalls = 0;
    for (int i = 0; i < 40 && got < 5; i++) begin
      out_ready = !(i >= 3 && i <= 6);
      in_valid  = (sent < 5);
      if (sent < 5) begin
        fill_tv(sent + 1);
        load_tile(1'b1, TW'(sent + 1));
      end
      #1;
      if (out_valid) begin
        check("bp_tag", longint'(out_tag), longint'(got + 1));
        check("bp_v0", elem(0), longint'(got + 1));
        check("bp_v15", elem(15), longint'(got + 1));
        if (out_ready) begin
          got++;
        end else begin
          stalls++;
          check("bp_stall_in_ready", longint'(in_ready), 0);
        end
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_emitted", longint'(got), 5);
    check("bp_stalls", longint'(stalls), 4);
    check("bp_count", longint'(out_count), 5);

    // Mid-stream reset: two beats are in flight, and neither may appear.
    out_ready = 1'b0;
    fill_tv(7);
    load_tile(1'b1, 4'd7);
    in_valid = 1'b1;
    @(posedge clk); #1;
    fill_tv(8);
    load_tile(1'b1, 4'd8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mrst_inflight_valid", longint'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("mrst_in_ready", longint'(in_ready), 0);
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      check("mrst_no_emit", longint'(out_valid), 0);
      @(posedge clk); #1;
    end
    check("mrst_count", longint'(out_count), 0);

    fill_tv(9);
    fill_ev(9);
    beat("post", 1'b1, 4'd9);
    @(posedge clk); #1;
    check("post_count", longint'(out_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wino_input_transform_stream.md
Name: wino_input_transform_stream

Overview:
- Streaming, back-pressured Winograd F(2x2,3x3) input-tile transform. Computes V = B^T·d·B on one 4x4 signed tile per beat.
- Sits between the tile-fetch buffer and the element-wise multiplier array.
- Successor to the fixed two-stage transform, adding:
  - valid/ready handshake with stall;
  - per-beat bypass mode;
  - sideband tag;
  - transfer counter;
  - exact, width-checked sign extension.

Parameters:
- WI, 8, signed input element width.
- WO, 12, signed output element width; must be >= WI+2 (elaboration error otherwise).
- TW, 4, sideband tag width.
- CW, 16, output transfer counter width.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  16*WI  tile d; element k=4r+c at in_data[k*WI +: WI].
- in_mode  in  1  0 = transform, 1 = bypass.
- in_tag  in  TW  sideband; travels with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  16*WO  tile V; element k at out_data[k*WO +: WO].
- out_tag  out  TW  tag of the beat on out_data.
- out_count  out  CW  number of completed output transfers, modulo 2^CW.

Behaviour:
- Reset: while rst=1 at a clock edge, clear all of the following to 0: out_valid, out_data, out_tag, out_count, both stage valid bits and all stage registers. in_ready is 0 while rst=1.
- Reset mid-operation: discard all in-flight beats; none are emitted afterwards.
- Pipeline: two register stages, S1 and S2, with S2 driving the outputs.
  - adv = !out_valid | out_ready.
  - in_ready = adv & !rst.
  - When adv=1, S2<=S1 and S1<=input; a stage's valid bit loads the upstream valid bit.
  - When adv=0, both stages hold and out_data/out_tag stay stable.
  - Accept on in_valid&in_ready.
  - Latency: 2 cycles from accept to out_valid with no stall; one beat per cycle at full throughput.
- Bubbles: when in_valid=0 and adv=1, load an invalid (bubble) into S1. Data registers may update or hold, but out_data is don't-care while out_valid=0.
- Stage 1 (T = B^T·d), with every operand sign-extended to WO before arithmetic, for each column c:
  - T0c = d0c − d2c
  - T1c = d1c + d2c
  - T2c = −d1c + d2c
  - T3c = d1c − d3c
- Stage 2 (V = T·B), for each row r:
  - Vr0 = Tr0 − Tr2
  - Vr1 = Tr1 + Tr2
  - Vr2 = −Tr1 + Tr2
  - Vr3 = Tr1 − Tr3
- Exactness: |V| <= 2^(WI+1), so results are exact in WO with no saturation or wrap.
- Bypass (in_mode=1): the stages pass elements through sign-extended to WO, so V=d. Mode is registered with the beat, so mixed-mode streams stay beat-accurate.
- Tag: out_tag is the in_tag of the accepted beat, same latency.
- out_count: increments by 1 on each cycle with out_valid&out_ready, and wraps from 2^CW−1 to 0.
- Simultaneous events: an accept and an emit in the same cycle are legal.

Test Plan:
- Reset/idle: hold rst 3 cycles then release → all outputs 0 during reset; in_ready=1 on the first cycle after release; out_valid stays 0 with no input.
- All-ones tile (every d=1), mode 0, out_ready=1 → 2 cycles later out_valid=1, out_data element 5 = 4, all other elements 0.
- Ramp tile d[k]=k, mode 0 → V row by row:
  - row 0: 0, −16, 0, 0
  - row 1: −4, 30, 2, −4
  - row 2: 0, 8, 0, 0
  - row 3: 0, −16, 0, 0
- Extreme and bypass:
  - all d=−128, mode 0 → element 5 = −512 (0xE00), others 0;
  - same tile in bypass → every element = −128 (0xF80).
- Back-pressure: 5 back-to-back beats with tags 1..5 and out_ready low for cycles 3–6 → in_ready drops while the output is stalled; out_data/out_tag stay stable; all 5 beats emerge in order with tags 1..5; out_count=5.
- Mid-stream reset: pulse rst with 2 beats in flight → neither beat is emitted; out_count=0; the next beat emerges with 2-cycle latency.
